stb16_word32_unpacker: RTL and testbench

Single-clock reader for 16-bit strobe streams (`dout`/`dout_stb` style, no backpressure) in the `mclk` domain. It pairs consecutive 16-bit strobed halves into 32-bit words and buffers them in a small FIFO. It presents the words downstream with a valid/ready handshake. It sits directly after the xclk→mclk 16-bit crossing FIFO and ahead of 32-bit command consumers.

---
 rtl/stb16_pkg.sv | 24 ++
 rtl/stb16_word32_unpacker_if.sv | 12 +
 rtl/myRAM_WxD_D.sv | 24 ++
 rtl/stb16_word32_unpacker.sv | 129 ++++++++++++
 tb/tb_stb16_word32_unpacker.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stb16_pkg.sv
// Shared types and helpers for the 16-to-32-bit strobe unpacker.
package stb16_pkg;

    localparam int unsigned HALF_W = 16;
    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word32_t;
    typedef logic [HALF_W-1:0] half16_t;

    typedef enum logic {
        PH_IDLE = 1'b0,
        PH_HALF = 1'b1
    } phase_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stb16_word32_unpacker_if.sv
// Downstream 32-bit word stream with valid/ready handshake.
interface stb16_word32_unpacker_if;
    import stb16_pkg::*;

    word32_t dout;
    logic    dout_valid;
    logic    dout_ready;

    modport master (output dout, output dout_valid, input dout_ready);
    modport slave  (input dout, input dout_valid, output dout_ready);

endinterface

// File: rtl/myRAM_WxD_D.sv
// Simple dual-port storage: synchronous write, combinational read.
module myRAM_WxD_D #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DATA_DEPTH = 2
) (
    input  logic                  xclk,
    input  logic                  we,
    input  logic [DATA_DEPTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_DEPTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata_c
);

    localparam int unsigned ENTRIES = 1 << DATA_DEPTH;

    logic [DATA_WIDTH-1:0] mem [ENTRIES];

    always_ff @(posedge xclk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/stb16_word32_unpacker.sv
// Pairs strobed 16-bit halves into 32-bit words and buffers them behind a valid/ready output.
// Optional STB16_OVERFLOW_CNT_EN adds a saturating dropped-word counter output ovf_count.
module stb16_word32_unpacker
    import stb16_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned LOW_FIRST = 1
) (
    input  logic                    mclk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [HALF_W-1:0]       din,
    input  logic                    din_stb,
    stb16_word32_unpacker_if.master out_if,
    output logic                    half_pending,
    output logic                    overflow,
    output logic [clog2(DEPTH):0]   level
`ifdef STB16_OVERFLOW_CNT_EN
    ,
    output logic [7:0]              ovf_count
`endif
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    phase_e        ph_q;
    phase_e        ph_d;
    half16_t       half_q;
    logic [AW:0]   wptr_q;
    logic [AW:0]   rptr_q;
    word32_t       ram_rdata_c;
    word32_t       word_c;
    logic          pop;
    logic          word_done;
    logic          accept;
    logic          drop;
    logic          ram_empty;
    logic          ram_full;
    logic          load;
    logic          ram_we;
    logic          ram_re;

    assign pop       = out_if.dout_valid & out_if.dout_ready;
    assign word_done = din_stb & (ph_q == PH_HALF) & ~flush;
    assign ram_empty = (wptr_q == rptr_q);
    assign ram_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign accept    = word_done & ((level < LW'(DEPTH)) | pop);
    assign drop      = word_done & ~accept;
    assign load      = ~out_if.dout_valid | pop;
    assign ram_re    = load & ~ram_empty;
    // An empty RAM with a free output slot lets the completed word bypass storage.
    assign ram_we    = accept & ~(load & ram_empty) & ~ram_full;
    assign word_c    = (LOW_FIRST != 0) ? {din, half_q} : {half_q, din};
    assign half_pending = (ph_q == PH_HALF);

    // Half-word phase: next state
    always_comb begin
        ph_d = ph_q;
        if (flush) begin
            ph_d = PH_IDLE;
        end else if (din_stb) begin
            ph_d = (ph_q == PH_IDLE) ? PH_HALF : PH_IDLE;
        end
    end

    // Half-word phase: state register
    always_ff @(posedge mclk) begin
        if (rst) ph_q <= PH_IDLE;
        else     ph_q <= ph_d;
    end

    myRAM_WxD_D #(
        .DATA_WIDTH (WORD_W),
        .DATA_DEPTH (AW)
    ) u_ram (
        .xclk    (mclk),
        .we      (ram_we),
        .waddr   (wptr_q[AW-1:0]),
        .wdata   (word_c),
        .raddr   (rptr_q[AW-1:0]),
        .rdata_c (ram_rdata_c)
    );

    // Pointers, output register and occupancy
    always_ff @(posedge mclk) begin
        if (rst || flush) begin
            half_q            <= '0;
            wptr_q            <= '0;
            rptr_q            <= '0;
            out_if.dout       <= '0;
            out_if.dout_valid <= 1'b0;
            level             <= '0;
        end else begin
            if (din_stb && (ph_q == PH_IDLE)) half_q <= din;
            if (ram_we) wptr_q <= wptr_q + LW'(1);
            if (ram_re) rptr_q <= rptr_q + LW'(1);
            if (load) begin
                if (!ram_empty) begin
                    out_if.dout       <= ram_rdata_c;
                    out_if.dout_valid <= 1'b1;
                end else if (accept) begin
                    out_if.dout       <= word_c;
                    out_if.dout_valid <= 1'b1;
                end else begin
                    out_if.dout_valid <= 1'b0;
                end
            end
            level <= level + LW'(accept) - LW'(pop);
        end
    end

    // Sticky overflow survives flush
    always_ff @(posedge mclk) begin
        if (rst)       overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

`ifdef STB16_OVERFLOW_CNT_EN
    always_ff @(posedge mclk) begin
        if (rst) begin
            ovf_count <= 8'd0;
        end else if (drop && (ovf_count != 8'hFF)) begin
            ovf_count <= ovf_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stb16_word32_unpacker.sv
// Randomized bench for stb16_word32_unpacker against a queue-based reference model.
module tb_stb16_word32_unpacker;
    import stb16_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = clog2(DEPTH) + 1;

    logic          mclk;
    logic          rst;
    logic          flush;
    logic          din_stb;
    logic          ready;
    logic [15:0]   din;
    logic          hp0, hp1;
    logic          ovf0, ovf1;
    logic [LW-1:0] lvl0, lvl1;
`ifdef STB16_OVERFLOW_CNT_EN
    logic [7:0]    cnt0, cnt1;
`endif

    stb16_word32_unpacker_if if0 ();
    stb16_word32_unpacker_if if1 ();

    assign if0.dout_ready = ready;
    assign if1.dout_ready = ready;

    stb16_word32_unpacker #(.DEPTH(DEPTH), .LOW_FIRST(1)) u_dut_lo (
        .mclk         (mclk),
        .rst          (rst),
        .flush        (flush),
        .din          (din),
        .din_stb      (din_stb),
        .out_if       (if0),
        .half_pending (hp0),
        .overflow     (ovf0),
        .level        (lvl0)
`ifdef STB16_OVERFLOW_CNT_EN
        ,
        .ovf_count    (cnt0)
`endif
    );

    stb16_word32_unpacker #(.DEPTH(DEPTH), .LOW_FIRST(0)) u_dut_hi (
        .mclk         (mclk),
        .rst          (rst),
        .flush        (flush),
        .din          (din),
        .din_stb      (din_stb),
        .out_if       (if1),
        .half_pending (hp1),
        .overflow     (ovf1),
        .level        (lvl1)
`ifdef STB16_OVERFLOW_CNT_EN
        ,
        .ovf_count    (cnt1)
`endif
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Reference model: words held in arrival order, head is what dout must show.
    word32_t     mq[$];
    word32_t     seen[$];
    bit          m_ph;
    logic [15:0] m_half;
    bit          m_ovf;
    int          m_cnt;
    int          checks;
    int          errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic word32_t swap_halves(input word32_t w);
        return {w[15:0], w[31:16]};
    endfunction

    function automatic void model_step();
        bit pop;
        bit room;
        if (rst) begin
            mq.delete();
            m_ph  = 1'b0;
            m_ovf = 1'b0;
            m_cnt = 0;
        end else if (flush) begin
            mq.delete();
            m_ph = 1'b0;
        end else begin
            pop  = (mq.size() > 0) && ready;
            room = (mq.size() < int'(DEPTH)) || pop;
            if (pop) void'(mq.pop_front());
            if (din_stb) begin
                if (!m_ph) begin
                    m_half = din;
                    m_ph   = 1'b1;
                end else begin
                    m_ph = 1'b0;
                    if (room) begin
                        mq.push_back({din, m_half});
                    end else begin
                        m_ovf = 1'b1;
                        if (m_cnt < 255) m_cnt++;
                    end
                end
            end
        end
    endfunction

    task automatic compare_all();
        check("valid_lo", 32'(if0.dout_valid), 32'(mq.size() > 0));
        check("valid_hi", 32'(if1.dout_valid), 32'(mq.size() > 0));
        check("level_lo", 32'(lvl0), 32'(mq.size()));
        check("level_hi", 32'(lvl1), 32'(mq.size()));
        check("hpend_lo", 32'(hp0), 32'(m_ph));
        check("hpend_hi", 32'(hp1), 32'(m_ph));
        check("ovf_lo", 32'(ovf0), 32'(m_ovf));
        check("ovf_hi", 32'(ovf1), 32'(m_ovf));
`ifdef STB16_OVERFLOW_CNT_EN
        check("ovfcnt_lo", 32'(cnt0), 32'(m_cnt));
        check("ovfcnt_hi", 32'(cnt1), 32'(m_cnt));
`endif
        if (mq.size() > 0) begin
            check("dout_lo", if0.dout, mq[0]);
            check("dout_hi", if1.dout, swap_halves(mq[0]));
        end
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic tick();
        if (if0.dout_valid && ready) seen.push_back(if0.dout);
        @(posedge mclk);
        model_step();
        #1;
        compare_all();
        @(negedge mclk);
    endtask

    task automatic send(input logic [15:0] h);
        din     = h;
        din_stb = 1'b1;
        tick();
        din_stb = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pct;
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        flush   = 1'b0;
        din_stb = 1'b0;
        din     = '0;
        ready   = 1'b0;
        m_ph    = 1'b0;
        m_half  = '0;
        m_ovf   = 1'b0;
        m_cnt   = 0;
        @(negedge mclk);
        tick();
        tick();
        check("rst_dout", if0.dout, 32'h0);
        check("rst_valid", 32'(if0.dout_valid), 32'd0);
        check("rst_level", 32'(lvl0), 32'd0);
        check("rst_ovf", 32'(ovf0), 32'd0);
        rst = 1'b0;

        // Basic pairing and one-cycle latency
        ready = 1'b1;
        send(16'h1234);
        check("pend_after_first", 32'(hp0), 32'd1);
        send(16'hABCD);
        check("word_lo_first", if0.dout, 32'hABCD1234);
        check("word_hi_first", if1.dout, 32'h1234ABCD);
        check("word_valid", 32'(if0.dout_valid), 32'd1);
        tick();
        check("word_popped", 32'(if0.dout_valid), 32'd0);

        // Overflow with a stalled consumer
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 10; i++) send(16'(16'h1000 + i));
        check("ovfl_level", 32'(lvl0), 32'd4);
        check("ovfl_flag", 32'(ovf0), 32'd1);
`ifdef STB16_OVERFLOW_CNT_EN
        check("ovfl_count", 32'(cnt0), 32'd1);
`endif
        seen.delete();
        ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("ovfl_drain_n", 32'(seen.size()), 32'd4);
        for (int j = 0; j < 4; j++) begin
            if (j < seen.size())
                check("ovfl_drain_word", seen[j], {16'(16'h1000 + 2*j + 1), 16'(16'h1000 + 2*j)});
        end

        // Full buffer, completing word and pop in the same cycle
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 9; i++) send(16'(16'h2000 + i));
        seen.delete();
        ready = 1'b1;
        send(16'h2009);
        check("fullpop_level", 32'(lvl0), 32'd4);
        check("fullpop_ovf", 32'(ovf0), 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check("fullpop_n", 32'(seen.size()), 32'd5);
        for (int j = 0; j < 5; j++) begin
            if (j < seen.size())
                check("fullpop_word", seen[j], {16'(16'h2000 + 2*j + 1), 16'(16'h2000 + 2*j)});
        end

        // Flush discards a held half; flush beats a simultaneous strobe
        send(16'h5555);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_pending", 32'(hp0), 32'd0);
        send(16'h0001);
        send(16'h0002);
        check("flush_realign", if0.dout, 32'h00020001);
        tick();
        flush = 1'b1;
        send(16'h7777);
        flush = 1'b0;
        check("flush_vs_stb", 32'(hp0), 32'd0);

        // Back-to-back strobes with ready held high never overflow
        do_reset();
        for (int i = 0; i < 40; i++) send(16'($urandom));
        tick();
        check("burst_no_ovf", 32'(ovf0), 32'd0);

        // Random gaps, random consumer
        pct = 85;
        for (int p = 0; p < 1000; p++) begin
            if ((p % 100) == 0) pct = ((p / 100) % 2 == 1) ? 30 : 85;
            for (int h = 0; h < 2; h++) begin
                int gap;
                gap = int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) begin
                    ready = ($urandom_range(0, 99) < pct);
                    tick();
                end
                ready = ($urandom_range(0, 99) < pct);
                send(16'($urandom));
            end
        end
        ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("final_level", 32'(lvl0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
